// File: rtl/slice_judge.sv
// slice_judge: per-frame block judgement (slice / miss / obstacle), one record per cycle, at most one event per block lifetime.
// Define SLICE_JUDGE_OBSTACLE_EN to enable obstacle hits; otherwise kind 3 records are ignored.
module slice_judge #(
    parameter int NUM_BLOCKS  = 16,
    parameter int HIT_Z       = 1024,
    parameter int MISS_Z      = 256,
    parameter int SPAWN_Z     = 8192,
    parameter int HIT_RADIUS  = 64,
    parameter int OBST_HALF_W = 128,
    localparam int IDW = $clog2(NUM_BLOCKS)
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           frame_start,
    input  logic [10:0]    saber_x,
    input  logic [9:0]     saber_y,
    input  logic [10:0]    player_x,
    input  logic           blk_valid,
    output logic           blk_ready,
    input  logic           blk_last,
    input  logic [IDW-1:0] blk_id,
    input  logic [1:0]     blk_kind,
    input  logic [10:0]    blk_x,
    input  logic [9:0]     blk_y,
    input  logic [13:0]    blk_z,
    output logic           block_sliced,
    output logic           block_missed,
    output logic           player_hit_by_obstacle,
    output logic           scan_done
);
`ifdef SLICE_JUDGE_OBSTACLE_EN
    localparam bit OBST_EN = 1'b1;
`else
    localparam bit OBST_EN = 1'b0;
`endif
    localparam logic [13:0] HIT_ZW   = 14'(HIT_Z);
    localparam logic [13:0] MISS_ZW  = 14'(MISS_Z);
    localparam logic [13:0] SPAWN_ZW = 14'(SPAWN_Z);
    localparam logic [11:0] RAD      = 12'(HIT_RADIUS);
    localparam logic [11:0] HALF_W   = 12'(OBST_HALF_W);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  drain_q, drain_d;
    logic [10:0]           sx_q, sx_d, px_q, px_d;
    logic [9:0]            sy_q, sy_d;
    logic                  s1_v_q, s1_v_d;
    logic [1:0]            s1_kind_q, s1_kind_d;
    logic [IDW-1:0]        s1_id_q, s1_id_d;
    logic [11:0]           s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d, s1_pdx_q, s1_pdx_d;
    logic                  s1_spawn_q, s1_spawn_d, s1_hit_q, s1_hit_d, s1_low_q, s1_low_d;
    logic [NUM_BLOCKS-1:0] flags_q, flags_d;
    logic                  sl_q, sl_d, ms_q, ms_d, ob_q, ob_d;
    logic                  live, obst;

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        sx_d    = sx_q;
        sy_d    = sy_q;
        px_d    = px_q;
        case (state_q)
            IDLE: if (frame_start) begin
                state_d = SCAN;
                sx_d    = saber_x;
                sy_d    = saber_y;
                px_d    = player_x;
            end
            SCAN: if (blk_valid && blk_last) state_d = DRAIN;
            DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_v_d     = blk_valid && state_q == SCAN;
        s1_kind_d  = blk_kind;
        s1_id_d    = blk_id;
        s1_dx_d    = blk_x >= sx_q ? {1'b0, blk_x - sx_q} : {1'b0, sx_q - blk_x};
        s1_dy_d    = blk_y >= sy_q ? {2'b0, blk_y - sy_q} : {2'b0, sy_q - blk_y};
        s1_pdx_d   = blk_x >= px_q ? {1'b0, blk_x - px_q} : {1'b0, px_q - blk_x};
        s1_spawn_d = blk_z >= SPAWN_ZW;
        s1_hit_d   = blk_z > MISS_ZW && blk_z <= HIT_ZW;
        s1_low_d   = blk_z <= MISS_ZW;
    end

    // Flag read and write share this cycle, so a same-id record right behind sees the update.
    always_comb begin
        flags_d = flags_q;
        sl_d    = 1'b0;
        ms_d    = 1'b0;
        ob_d    = 1'b0;
        obst    = s1_kind_q == 2'd3;
        live    = s1_v_q && s1_kind_q != 2'd0 && (OBST_EN || !obst);
        if (live) begin
            if (s1_spawn_q) flags_d[s1_id_q] = 1'b0;
            else if (!flags_q[s1_id_q]) begin
                sl_d = !obst && s1_hit_q && s1_dx_q <= RAD && s1_dy_q <= RAD;
                ms_d = !obst && s1_low_q;
                ob_d = obst && s1_hit_q && s1_pdx_q <= HALF_W;
                flags_d[s1_id_q] = sl_d | ms_d | ob_d | (obst & s1_low_q);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            px_q       <= '0;
            s1_v_q     <= 1'b0;
            s1_kind_q  <= '0;
            s1_id_q    <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_pdx_q   <= '0;
            s1_spawn_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_low_q   <= 1'b0;
            flags_q    <= '0;
            sl_q       <= 1'b0;
            ms_q       <= 1'b0;
            ob_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            px_q       <= px_d;
            s1_v_q     <= s1_v_d;
            s1_kind_q  <= s1_kind_d;
            s1_id_q    <= s1_id_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_pdx_q   <= s1_pdx_d;
            s1_spawn_q <= s1_spawn_d;
            s1_hit_q   <= s1_hit_d;
            s1_low_q   <= s1_low_d;
            flags_q    <= flags_d;
            sl_q       <= sl_d;
            ms_q       <= ms_d;
            ob_q       <= ob_d;
        end
    end

    assign blk_ready              = state_q == SCAN;
    assign scan_done              = state_q == DONE;
    assign block_sliced           = sl_q;
    assign block_missed           = ms_q;
    assign player_hit_by_obstacle = ob_q;
endmodule

// File: tb/tb_slice_judge.sv
// tb_slice_judge: directed + randomized frames checked cycle by cycle against a rule-level judgement model.
module tb_slice_judge;
`ifdef SLICE_JUDGE_OBSTACLE_EN
    localparam bit OBST = 1'b1;
`else
    localparam bit OBST = 1'b0;
`endif
    logic clk_in = 1'b0, rst_in = 1'b1, frame_start = 1'b0;
    logic [10:0] saber_x = '0, player_x = '0, blk_x = '0;
    logic [9:0] saber_y = '0, blk_y = '0;
    logic blk_valid = 1'b0, blk_last = 1'b0, blk_ready;
    logic [3:0] blk_id = '0;
    logic [1:0] blk_kind = '0;
    logic [13:0] blk_z = '0;
    logic block_sliced, block_missed, player_hit_by_obstacle, scan_done;

    slice_judge dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start),
        .saber_x(saber_x), .saber_y(saber_y), .player_x(player_x),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
        .blk_id(blk_id), .blk_kind(blk_kind), .blk_x(blk_x), .blk_y(blk_y), .blk_z(blk_z),
        .block_sliced(block_sliced), .block_missed(block_missed),
        .player_hit_by_obstacle(player_hit_by_obstacle), .scan_done(scan_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {int id; int kind; int x; int y; int z;} rec_t;
    rec_t recs[$];
    int n_vec = 0, n_err = 0, edge_n = 0, m_free = 0;
    int msx = 0, msy = 0, mpx = 0;
    int cnt_sl, cnt_ms, cnt_ob, cnt_done;
    bit m_scan = 0;
    bit m_flag [16];
    int exp_ev [int];
    bit exp_done [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp_v, edge_n);
        end
    endtask

    // Event codes: 1 slice, 2 miss, 3 obstacle hit, 4 silent obstacle expiry.
    task automatic judge(output int ev);
        int k = blk_kind, id = blk_id, z = blk_z;
        int dx = int'(blk_x) - msx, dy = int'(blk_y) - msy, pdx = int'(blk_x) - mpx;
        bit in_hit = z > 256 && z <= 1024, low = z <= 256;
        ev = 0;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        if (pdx < 0) pdx = -pdx;
        if (k == 0 || (k == 3 && !OBST)) return;
        if (z >= 8192) begin m_flag[id] = 0; return; end
        if (m_flag[id]) return;
        if (k != 3) ev = (in_hit && dx <= 64 && dy <= 64) ? 1 : low ? 2 : 0;
        else ev = (in_hit && pdx <= 128) ? 3 : low ? 4 : 0;
        if (ev != 0) m_flag[id] = 1;
        if (ev == 4) ev = 0;
    endtask

    task automatic step();
        int ev, e;
        @(posedge clk_in);
        edge_n++;
        if (rst_in) begin
            m_scan = 0;
            foreach (m_flag[i]) m_flag[i] = 0;
            exp_ev.delete();
            exp_done.delete();
            m_free = edge_n + 1;
        end else if (!m_scan && frame_start && edge_n >= m_free) begin
            m_scan = 1;
            msx = saber_x; msy = saber_y; mpx = player_x;
        end else if (m_scan && blk_valid) begin
            judge(ev);
            if (ev != 0) exp_ev[edge_n + 1] = ev;
            if (blk_last) begin
                m_scan = 0;
                exp_done[edge_n + 2] = 1;
                m_free = edge_n + 4;
            end
        end
        #1;
        e = exp_ev.exists(edge_n) ? exp_ev[edge_n] : 0;
        chk("blk_ready", blk_ready, m_scan);
        chk("block_sliced", block_sliced, e == 1);
        chk("block_missed", block_missed, e == 2);
        chk("player_hit", player_hit_by_obstacle, e == 3);
        chk("scan_done", scan_done, exp_done.exists(edge_n));
        cnt_sl += block_sliced; cnt_ms += block_missed;
        cnt_ob += player_hit_by_obstacle; cnt_done += scan_done;
    endtask

    task automatic add(input int id, input int kind, input int x, input int y, input int z);
        recs.push_back('{id, kind, x, y, z});
    endtask

    task automatic frame(input int sx, input int sy, input int px, input bit rnd);
        cnt_sl = 0; cnt_ms = 0; cnt_ob = 0; cnt_done = 0;
        saber_x = 11'(sx); saber_y = 10'(sy); player_x = 11'(px);
        frame_start = 1; step(); frame_start = 0;
        for (int i = 0; i < recs.size(); i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin blk_valid = 0; step(); end
            blk_valid = 1; blk_last = (i == recs.size() - 1);
            blk_id = 4'(recs[i].id); blk_kind = 2'(recs[i].kind);
            blk_x = 11'(recs[i].x); blk_y = 10'(recs[i].y); blk_z = 14'(recs[i].z);
            frame_start = (i == 1);
            if (i == 1) begin saber_x = 11'($urandom); saber_y = 10'($urandom); player_x = 11'($urandom); end
            step();
        end
        blk_valid = 0; blk_last = 0; frame_start = 0;
        repeat (5) step();
        chk("done_count", cnt_done, 1);
    endtask

    initial begin
        step(); step();
        rst_in = 0; step();
        // Slice, then repeat: already judged.
        recs.delete(); add(2, 1, 430, 340, 800);
        frame(400, 300, 0, 0); chk("slice_once", cnt_sl, 1);
        frame(400, 300, 0, 0); chk("slice_repeat", cnt_sl, 0);
        // Miss, no repeat, respawn, miss again.
        recs.delete(); add(5, 2, 1500, 300, 200);
        frame(400, 300, 0, 0); chk("miss_once", cnt_ms, 1);
        frame(400, 300, 0, 0); chk("miss_repeat", cnt_ms, 0);
        recs.delete(); add(5, 2, 1500, 300, 9000);
        frame(400, 300, 0, 0); chk("respawn_quiet", cnt_ms + cnt_sl, 0);
        recs.delete(); add(5, 2, 1500, 300, 200);
        frame(400, 300, 0, 0); chk("miss_rearmed", cnt_ms, 1);
        // Inclusive boundaries.
        recs.delete();
        add(6, 1, 464, 364, 1024); add(7, 1, 465, 300, 800);
        add(8, 2, 1500, 300, 257); add(8, 2, 1500, 300, 256);
        frame(400, 300, 0, 0);
        chk("bound_slice", cnt_sl, 1); chk("bound_miss", cnt_ms, 1);
        // Obstacle.
        recs.delete(); add(9, 3, 700, 0, 500); add(10, 3, 729, 0, 500);
        frame(400, 300, 600, 0);
        chk("obstacle_hits", cnt_ob, OBST ? 1 : 0); chk("obstacle_other", cnt_sl + cnt_ms, 0);
        // Re-arm all ids, then back-to-back throughput.
        recs.delete(); for (int i = 0; i < 16; i++) add(i, 1, 0, 0, 9000);
        frame(400, 300, 0, 0); chk("rearm_quiet", cnt_sl + cnt_ms, 0);
        recs.delete();
        for (int i = 0; i < 16; i++) if (i % 2 == 0) add(i, 1, 400, 300, 600); else add(i, 2, 1800, 0, 100);
        frame(400, 300, 0, 0);
        chk("thru_slices", cnt_sl, 8); chk("thru_misses", cnt_ms, 8);
        // Reset the cycle after a slice-qualifying record is accepted.
        cnt_sl = 0;
        saber_x = 400; saber_y = 300; frame_start = 1; step(); frame_start = 0;
        blk_valid = 1; blk_last = 1; blk_id = 3; blk_kind = 1; blk_x = 400; blk_y = 300; blk_z = 900;
        step();
        blk_valid = 0; blk_last = 0; rst_in = 1; step(); rst_in = 0;
        repeat (4) step();
        chk("reset_no_pulse", cnt_sl, 0);
        recs.delete(); add(3, 1, 400, 300, 900);
        frame(400, 300, 0, 0); chk("reset_flags_clear", cnt_sl, 1);
        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int sx = $urandom_range(0, 2047), sy = $urandom_range(0, 1023), px = $urandom_range(0, 2047);
            int n = $urandom_range(1, 12);
            recs.delete();
            for (int i = 0; i < n; i++) begin
                int k = $urandom_range(0, 3), z = 0, x, y;
                int zb[6] = '{256, 257, 1024, 1025, 8191, 8192};
                x = ((k == 3 ? px : sx) + int'($urandom_range(0, 300)) - 150) & 2047;
                y = (sy + int'($urandom_range(0, 160)) - 80) & 1023;
                case ($urandom_range(0, 4))
                    0: z = $urandom_range(0, 256);
                    1: z = $urandom_range(257, 1024);
                    2: z = $urandom_range(1025, 8191);
                    3: z = $urandom_range(8192, 16383);
                    default: z = zb[$urandom_range(0, 5)];
                endcase
                add($urandom_range(0, 15), k, x, y, z);
            end
            frame(sx, sy, px, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/slice_judge.md
# slice_judge

Per-frame judgement stage directly upstream of `game_state`. Each frame it scans the block-position table one record per cycle and compares each block against the saber and player positions. It emits the single-cycle `block_sliced`, `block_missed` and `player_hit_by_obstacle` pulses that `game_state` consumes. A per-block judged flag guarantees at most one event per block lifetime.

## Interface

Parameters:
- `NUM_BLOCKS`, 16: block table depth; `blk_id` width is clog2(NUM_BLOCKS).
- `HIT_Z`, 1024: upper z bound of the hit window, inclusive.
- `MISS_Z`, 256: z at or below which an unjudged block counts as missed.
- `SPAWN_Z`, 8192: z at or above which a record re-arms its id.
- `HIT_RADIUS`, 64: max |dx| and max |dy| for a slice.
- `OBST_HALF_W`, 128: max |dx| for an obstacle hit.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  pulse; starts a scan.
- `saber_x`  in  11  saber tip x, sampled at scan start.
- `saber_y`  in  10  saber tip y, sampled at scan start.
- `player_x`  in  11  player body x, sampled at scan start.
- `blk_valid`  in  1  record valid.
- `blk_ready`  out  1  record accepted when `blk_valid & blk_ready`.
- `blk_last`  in  1  final record of the frame.
- `blk_id`  in  clog2(NUM_BLOCKS)  table index.
- `blk_kind`  in  2  0 empty, 1 red, 2 blue, 3 obstacle.
- `blk_x`  in  11  block x.
- `blk_y`  in  10  block y.
- `blk_z`  in  14  block depth; unsigned, decreasing toward the player.
- `block_sliced`  out  1  event pulse.
- `block_missed`  out  1  event pulse.
- `player_hit_by_obstacle`  out  1  event pulse.
- `scan_done`  out  1  pulse; frame judgement complete.

## Operation

FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: when `frame_start` is high, latch `saber_x`, `saber_y` and `player_x`, then go to SCAN.
- SCAN: `blk_ready`=1. Accepting a record with `blk_last`=1 moves the FSM to DRAIN.
- DRAIN: lasts 2 cycles while the pipeline empties, then goes to DONE.
- DONE: asserts `scan_done` for 1 cycle, then returns to IDLE.
- `frame_start` outside IDLE is ignored.

Pipeline:
- Stage 1 registers the record, |dx| and |dy| (unsigned, computed 12 bits wide), and the z comparisons.
- Stage 2 reads and writes the judged-flag vector (`NUM_BLOCKS` bits) in the same cycle and drives the event outputs.
- Back-to-back records with the same id therefore see the updated flag with no hazard.

Stage-2 rules per record, evaluated in priority order:
1. kind 0: no event, no flag change.
2. `blk_z >= SPAWN_Z`: clear the flag, no event.
3. Flag set: no event.
4. kind 1/2, `MISS_Z < blk_z <= HIT_Z`, |dx| ≤ HIT_RADIUS and |dy| ≤ HIT_RADIUS: pulse `block_sliced`, set the flag.
5. kind 1/2, `blk_z <= MISS_Z`: pulse `block_missed`, set the flag.
6. kind 3, `MISS_Z < blk_z <= HIT_Z`, |player_x − blk_x| ≤ OBST_HALF_W: pulse `player_hit_by_obstacle`, set the flag.
7. kind 3, `blk_z <= MISS_Z`: set the flag silently.

Event rules:
- At most one event pulse per cycle.
- Consecutive records may produce events on consecutive cycles.
- Comparisons are inclusive exactly as written above.

## Timing

- Record accepted at cycle N: its event pulse appears at N+2.
- `blk_last` accepted at cycle N: `scan_done` appears at N+3.
- Reset values: FSM in IDLE; `blk_ready`=0; all three event outputs 0; `scan_done`=0; all judged flags 0; pipeline valids 0; latched positions 0.
- Reset mid-scan: the in-flight pipeline is discarded and no event pulses appear after reset.
- `blk_valid` low during SCAN inserts bubbles and produces no events.
- A frame with a single record carrying `blk_last` is legal.

## Configuration

- `SLICE_JUDGE_OBSTACLE_EN` defined: rule 6 is active as specified.
- Undefined: kind 3 records are treated like kind 0, and `player_hit_by_obstacle` is tied to 0.

## Test plan

- Slice: saber (400,300); record id 2, kind 1, (430,340,800), last. Required: `block_sliced` at N+2; `scan_done` at N+3. Repeat the frame: no event.
- Miss then respawn: id 5, kind 2, z=200, far from saber → `block_missed` once. Next frame, same record → no event. Then a frame with z=9000 → no event. Then z=200 again → `block_missed` again.
- Boundaries with saber (400,300):
  - dx=64, dy=64, z=1024 → slice.
  - dx=65 → no event.
  - z=257, far away → no event.
  - z=256 → miss.
- Obstacle: player_x=600; kind 3 at (700,·,500) → `player_hit_by_obstacle`, if `SLICE_JUDGE_OBSTACLE_EN` is defined; otherwise no pulse. x=729 → no event.
- Throughput: 16 back-to-back valid records, ids 0–15, alternating slice and miss. Required: 16 consecutive pulses in order. `frame_start` mid-scan is ignored.
- Reset asserted the cycle after a slice-qualifying record is accepted: no pulse appears, all flags are clear, and the FSM is in IDLE.
